// File: rtl/ldpc_qc_encoder.sv
// Systematic quasi-cyclic LDPC encoder: accepts message bits serially and emits the
// codeword serially (message bits, then parity blocks 0..N_PAR-1).
module ldpc_qc_encoder #(
    parameter int L          = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int N_INFO     = 3,
    parameter int N_PAR      = 3,
    parameter logic [N_INFO*N_PAR*L-1:0] GEN_ROWS = {(N_INFO*N_PAR){{(L-1){1'b0}}, 1'b1}}
) (
    input  logic clk,
    input  logic rst_n,
    input  logic msg_bit,
    input  logic msg_valid,
    output logic msg_ready,
    output logic code_bit,
    output logic code_valid,
    input  logic code_ready,
    output logic code_sof,
    output logic code_eof,
    output logic busy
);

    localparam int MSG_LEN = N_INFO * L;
    localparam int PAR_LEN = N_PAR * L;
    localparam int MC_W    = $clog2(MSG_LEN);
    localparam int PC_W    = $clog2(PAR_LEN);
    localparam int BLK_W   = MC_W - ADDR_WIDTH;
    localparam int PB_W    = PC_W - ADDR_WIDTH;

    typedef enum logic {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [MC_W-1:0]       msg_cnt;
    logic [PC_W-1:0]       par_cnt;
    logic [L-1:0]          acc [N_PAR];
    logic [L-1:0]          rot [N_PAR];
    logic [L-1:0]          gen [N_INFO][N_PAR];
    logic                  free;
    logic                  msg_acc;
    logic                  par_load;
    logic                  last_msg;
    logic                  last_par;
    logic                  blk_end;
    logic                  par_bit;
    logic [BLK_W-1:0]      msg_blk;
    logic [BLK_W-1:0]      blk_nxt;
    logic [PB_W-1:0]       par_blk;
    logic [ADDR_WIDTH-1:0] par_idx;

    for (genvar gi = 0; gi < N_INFO; gi++) begin : g_gen_i
        for (genvar gj = 0; gj < N_PAR; gj++) begin : g_gen_j
            assign gen[gi][gj] = GEN_ROWS[(gi*N_PAR+gj)*L +: L];
        end
    end

    // L is a power of two, so block index and bit offset are plain counter slices.
    assign msg_blk = msg_cnt[MC_W-1:ADDR_WIDTH];
    assign blk_end = &msg_cnt[ADDR_WIDTH-1:0];
    assign blk_nxt = last_msg ? '0 : msg_blk + BLK_W'(1);
    assign par_blk = par_cnt[PC_W-1:PB_W == 0 ? PC_W-1 : ADDR_WIDTH];
    assign par_idx = par_cnt[ADDR_WIDTH-1:0];
    assign par_bit = acc[par_blk][par_idx];

    assign free     = !code_valid || code_ready;
    assign msg_acc  = msg_valid && msg_ready;
    assign last_msg = msg_acc && (msg_cnt == MC_W'(MSG_LEN - 1));
    assign last_par = par_load && (par_cnt == PC_W'(PAR_LEN - 1));
    assign busy     = (msg_cnt != '0) || (state == ST_PAR);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_MSG;
        else        state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_MSG: if (last_msg) state_nxt = ST_PAR;
            ST_PAR: if (last_par) state_nxt = ST_MSG;
        endcase
    end

    always_comb begin
        msg_ready = 1'b0;
        par_load  = 1'b0;
        case (state)
            ST_MSG: msg_ready = free;
            ST_PAR: par_load  = free;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_cnt    <= '0;
            par_cnt    <= '0;
            code_bit   <= 1'b0;
            code_valid <= 1'b0;
            code_sof   <= 1'b0;
            code_eof   <= 1'b0;
            for (int j = 0; j < N_PAR; j++) begin
                acc[j] <= '0;
                rot[j] <= gen[0][j];
            end
        end else begin
            if (msg_acc) begin
                code_bit   <= msg_bit;
                code_valid <= 1'b1;
                code_sof   <= (msg_cnt == '0);
                code_eof   <= 1'b0;
                msg_cnt    <= last_msg ? '0 : msg_cnt + MC_W'(1);
            end else if (par_load) begin
                code_bit   <= par_bit;
                code_valid <= 1'b1;
                code_sof   <= 1'b0;
                code_eof   <= last_par;
                par_cnt    <= last_par ? '0 : par_cnt + PC_W'(1);
            end else if (free) begin
                code_valid <= 1'b0;
            end

            // Each message bit adds the current circulant row into every parity block.
            for (int j = 0; j < N_PAR; j++) begin
                if (msg_acc) begin
                    if (msg_bit) acc[j] <= acc[j] ^ rot[j];
                    rot[j] <= blk_end ? gen[blk_nxt][j] : {rot[j][L-2:0], rot[j][L-1]};
                end
                if (last_par) acc[j] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_qc_encoder.sv
// Scoreboard bench for ldpc_qc_encoder: a small L=4 instance with hand-computed parity
// and a default-parameter instance with identity generators.
module tb_ldpc_qc_encoder;

    localparam logic [15:0] SGEN = 16'h8261;

    typedef struct packed {
        logic b;
        logic sof;
        logic eof;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic msg_bit, msg_valid, msg_ready;
    logic code_bit, code_valid, code_sof, code_eof, busy;
    logic code_ready = 1'b1;
    logic b_msg_bit, b_msg_valid, b_msg_ready;
    logic b_code_bit, b_code_valid, b_code_sof, b_code_eof, b_busy;
    logic b_code_ready;

    ldpc_qc_encoder #(
        .L(4), .ADDR_WIDTH(2), .N_INFO(2), .N_PAR(2), .GEN_ROWS(SGEN)
    ) u_small (
        .clk(clk), .rst_n(rst_n),
        .msg_bit(msg_bit), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .code_bit(code_bit), .code_valid(code_valid), .code_ready(code_ready),
        .code_sof(code_sof), .code_eof(code_eof), .busy(busy)
    );

    ldpc_qc_encoder u_big (
        .clk(clk), .rst_n(rst_n),
        .msg_bit(b_msg_bit), .msg_valid(b_msg_valid), .msg_ready(b_msg_ready),
        .code_bit(b_code_bit), .code_valid(b_code_valid), .code_ready(b_code_ready),
        .code_sof(b_code_sof), .code_eof(b_code_eof), .busy(b_busy)
    );

    exp_t sb[$];
    exp_t bsb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pops    = 0;
    int   run     = 0;
    int   last_run = 0;
    int   sof_cyc = -1;
    int   acc_cyc = 0;
    bit   in_par  = 1'b0;
    bit   rand_ready = 1'b0;
    bit   pv = 1'b0, pr = 1'b0;
    logic [2:0] pd = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        code_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Small-instance monitor: scoreboard pop, hold-under-backpressure, no msg_ready in parity.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pv  = 1'b0;
            run = 0;
        end else begin
            if (pv && !pr)
                check("hold_under_backpressure", {code_valid, code_bit, code_sof, code_eof}, {1'b1, pd});
            if (in_par && !(code_valid && code_eof))
                check("msg_ready_in_parity", msg_ready, 1'b0);
            run = code_valid ? run + 1 : 0;
            if (code_valid && code_sof && sof_cyc < 0) sof_cyc = cyc;
            if (code_valid && code_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL small_unexpected_output: got bit %0b sof %0b eof %0b, expected none",
                             code_bit, code_sof, code_eof);
                end else begin
                    e = sb.pop_front();
                    n_tests--;
                    check("small_code", {code_bit, code_sof, code_eof}, e);
                    pops++;
                    if (code_eof) begin
                        in_par   = 1'b0;
                        last_run = run;
                    end
                end
            end
            pv = code_valid;
            pr = code_ready;
            pd = {code_bit, code_sof, code_eof};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_code_valid && b_code_ready) begin
            if (bsb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL big_unexpected_output: got bit %0b, expected none", b_code_bit);
            end else begin
                e = bsb.pop_front();
                check("big_code", {b_code_bit, b_code_sof, b_code_eof}, e);
            end
        end
    end

    task automatic send_bit(input logic b, input bit first);
        int n   = 0;
        bit got = 1'b0;
        msg_valid = 1'b1;
        msg_bit   = b;
        while (!got && n < 200) begin
            @(negedge clk);
            got = msg_ready;
            if (got && first) acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL msg_accept_timeout: got no msg_ready in %0d cycles, expected acceptance", n);
        end
    endtask

    // p0/p1 hold parity bit c at index c.
    task automatic run_frame(input logic [7:0] m, input logic [3:0] p0, input logic [3:0] p1, input bit pulses);
        for (int i = 0; i < 8; i++) sb.push_back(exp_t'({m[i], i == 0, 1'b0}));
        for (int c = 0; c < 4; c++) sb.push_back(exp_t'({p0[c], 1'b0, 1'b0}));
        for (int c = 0; c < 4; c++) sb.push_back(exp_t'({p1[c], 1'b0, c == 3}));
        for (int i = 0; i < 8; i++) send_bit(m[i], i == 0);
        msg_valid = 1'b0;
        in_par    = 1'b1;
        if (pulses) begin
            repeat (4) begin
                msg_valid = 1'b1;
                msg_bit   = 1'b1;
                @(negedge clk);
                check("pulse_not_accepted", msg_ready, 1'b0);
                @(posedge clk);
                #1;
                msg_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic big_frame();
        logic [95:0] m;
        int n;
        m = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 96; i++) bsb.push_back(exp_t'({m[i], i == 0, 1'b0}));
        for (int j = 0; j < 3; j++)
            for (int c = 0; c < 32; c++)
                bsb.push_back(exp_t'({m[c] ^ m[32+c] ^ m[64+c], 1'b0, (j == 2) && (c == 31)}));
        for (int i = 0; i < 96; i++) begin
            bit got = 1'b0;
            n = 0;
            b_msg_valid = 1'b1;
            b_msg_bit   = m[i];
            while (!got && n < 400) begin
                @(negedge clk);
                got = b_msg_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!got) begin
                n_tests++;
                n_fail++;
                $display("FAIL big_accept_timeout: got no msg_ready at bit %0d, expected acceptance", i);
            end
        end
        b_msg_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bsb.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0 || bsb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d outputs pending, expected 0", sb.size(), bsb.size());
        end
    endtask

    initial begin
        int n;
        int pops0;
        rst_n = 1'b0;
        msg_valid = 1'b0;
        msg_bit = 1'b0;
        b_msg_valid = 1'b0;
        b_msg_bit = 1'b0;
        b_code_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_code_valid", code_valid, 1'b0);
        check("reset_sof_eof_bit", {code_sof, code_eof, code_bit}, 3'b000);
        check("reset_busy", busy, 1'b0);
        check("reset_big_valid", b_code_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single message bit: latency 1, 16 back-to-back valid cycles.
        run_frame(8'b0000_0001, 4'b0001, 4'b0110, 1'b0);
        drain();
        check("t1_latency", sof_cyc - acc_cyc, 1);
        check("t1_valid_run", last_run, 16);

        // Rotation within block 0, then the last bit of block 1.
        run_frame(8'b0000_0100, 4'b0100, 4'b1001, 1'b0);
        run_frame(8'b1000_0000, 4'b0001, 4'b0100, 1'b0);
        drain();

        // Linearity, back-to-back frames.
        run_frame(8'b0000_0101, 4'b0101, 4'b1111, 1'b0);
        run_frame(8'b0000_0101, 4'b0101, 4'b1111, 1'b0);
        drain();

        // Same frames under random backpressure, with msg_valid pulses during parity.
        rand_ready = 1'b1;
        run_frame(8'b0000_0101, 4'b0101, 4'b1111, 1'b1);
        run_frame(8'b0000_0101, 4'b0101, 4'b1111, 1'b1);
        drain();
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset after two parity bits, then an all-zero frame.
        pops0 = pops;
        run_frame(8'b0000_0101, 4'b0101, 4'b1111, 1'b0);
        n = 0;
        while (pops < pops0 + 10 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_reached_parity", pops - pops0, 10);
        check("t5_busy_mid_parity", busy, 1'b1);
        rst_n = 1'b0;
        sb.delete();
        in_par = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_reset_valid_eof", {code_valid, code_eof}, 2'b00);
        check("t5_reset_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_after_reset_busy", busy, 1'b0);
        check("t5_after_reset_ready", msg_ready, 1'b1);
        @(posedge clk);
        #1;
        run_frame(8'b0000_0000, 4'b0000, 4'b0000, 1'b0);
        drain();

        // Default parameters, identity generators.
        big_frame();
        big_frame();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
